// File: rtl/system_unit.sv
// Execute-stage SYSTEM unit: owns the 64-bit cycle/time/instret counters, answers
// counter-half reads through a one-entry result buffer and pulses traps for SCALL/SBREAK.
module system_unit #(
    parameter int          DATA_SIZE  = 32,
    parameter int          TIME_DIV   = 4,
    parameter logic [63:0] CYCLE_INIT = 64'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [2:0]           sysop,
    input  logic [4:0]           issue_rd,
    input  logic                 retire,
    input  logic                 flush,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [DATA_SIZE-1:0] result_data,
    output logic [4:0]           result_rd,
    output logic                 trap_valid,
    output logic                 trap_cause
);

    typedef enum logic [2:0] {
        SYS_RDCYCLE    = 3'd0,
        SYS_RDCYCLEH   = 3'd1,
        SYS_RDTIME     = 3'd2,
        SYS_RDTIMEH    = 3'd3,
        SYS_RDINSTRET  = 3'd4,
        SYS_RDINSTRETH = 3'd5,
        SYS_SCALL      = 3'd6,
        SYS_SBREAK     = 3'd7
    } t_sysop;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } t_buf_state;

    // A one-cycle-per-tick divider still needs a 1-bit register to stay legal.
    localparam int                PS_W    = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
    localparam logic [PS_W-1:0]   PS_LAST = PS_W'(TIME_DIV - 1);

    logic [63:0]   cycle_cnt;
    logic [63:0]   time_cnt;
    logic [63:0]   instret_cnt;
    logic [PS_W-1:0] prescale;
    logic          time_tick;

    t_sysop        op;
    t_buf_state    buf_state;
    logic          accept;
    logic          is_trap;
    logic          is_read;
    logic [63:0]   sel_counter;
    logic [31:0]   read_half;

    assign op          = t_sysop'(sysop);
    assign issue_ready = !result_valid || result_ready;
    assign accept      = issue_valid && issue_ready;
    assign is_trap     = (op == SYS_SCALL) || (op == SYS_SBREAK);
    assign is_read     = !is_trap;
    assign time_tick   = (prescale == PS_LAST);

    // Counters free-run regardless of issue, back-pressure or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= CYCLE_INIT;
            time_cnt    <= 64'd0;
            instret_cnt <= 64'd0;
            prescale    <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (time_tick) begin
                time_cnt <= time_cnt + 64'd1;
                prescale <= '0;
            end else begin
                prescale <= prescale + PS_W'(1);
            end
            if (retire) begin
                instret_cnt <= instret_cnt + 64'd1;
            end
        end
    end

    always_comb begin
        sel_counter = cycle_cnt;
        case (op)
            SYS_RDCYCLE, SYS_RDCYCLEH:     sel_counter = cycle_cnt;
            SYS_RDTIME, SYS_RDTIMEH:       sel_counter = time_cnt;
            SYS_RDINSTRET, SYS_RDINSTRETH: sel_counter = instret_cnt;
            default:                       sel_counter = cycle_cnt;
        endcase
        read_half = sysop[0] ? sel_counter[63:32] : sel_counter[31:0];
    end

    // Result buffer and trap pulse; flush wins over anything accepted alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_state    <= BUF_EMPTY;
            result_valid <= 1'b0;
            result_data  <= '0;
            result_rd    <= 5'd0;
            trap_valid   <= 1'b0;
            trap_cause   <= 1'b0;
        end else if (flush) begin
            buf_state    <= BUF_EMPTY;
            result_valid <= 1'b0;
            trap_valid   <= 1'b0;
        end else begin
            trap_valid <= accept && is_trap;
            if (accept && is_trap) begin
                trap_cause <= (op == SYS_SBREAK);
            end
            if (accept && is_read) begin
                buf_state    <= BUF_FULL;
                result_valid <= 1'b1;
                result_data  <= DATA_SIZE'(read_half);
                result_rd    <= issue_rd;
            end else if (buf_state == BUF_FULL && result_ready) begin
                buf_state    <= BUF_EMPTY;
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_system_unit.sv
// Directed bench for system_unit: three instances (default, TIME_DIV=1, preloaded
// cycle counter) share one stimulus stream and are checked against hand-derived values.
module tb_system_unit;

    localparam logic [2:0] OP_RDCYCLE    = 3'd0;
    localparam logic [2:0] OP_RDCYCLEH   = 3'd1;
    localparam logic [2:0] OP_RDTIME     = 3'd2;
    localparam logic [2:0] OP_RDINSTRET  = 3'd4;
    localparam logic [2:0] OP_SCALL      = 3'd6;
    localparam logic [2:0] OP_SBREAK     = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [2:0]  sysop;
    logic [4:0]  issue_rd;
    logic        retire;
    logic        flush;
    logic        result_ready;

    logic        issue_ready_w  [3];
    logic        result_valid_w [3];
    logic [31:0] result_data_w  [3];
    logic [4:0]  result_rd_w    [3];
    logic        trap_valid_w   [3];
    logic        trap_cause_w   [3];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    system_unit #(.DATA_SIZE(32), .TIME_DIV(4), .CYCLE_INIT(64'h0)) u_dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready_w[0]),
        .sysop(sysop), .issue_rd(issue_rd), .retire(retire), .flush(flush),
        .result_valid(result_valid_w[0]), .result_ready(result_ready),
        .result_data(result_data_w[0]), .result_rd(result_rd_w[0]),
        .trap_valid(trap_valid_w[0]), .trap_cause(trap_cause_w[0])
    );

    system_unit #(.DATA_SIZE(32), .TIME_DIV(1), .CYCLE_INIT(64'h0)) u_div1 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready_w[1]),
        .sysop(sysop), .issue_rd(issue_rd), .retire(retire), .flush(flush),
        .result_valid(result_valid_w[1]), .result_ready(result_ready),
        .result_data(result_data_w[1]), .result_rd(result_rd_w[1]),
        .trap_valid(trap_valid_w[1]), .trap_cause(trap_cause_w[1])
    );

    system_unit #(.DATA_SIZE(32), .TIME_DIV(4), .CYCLE_INIT(64'h0000_0000_FFFF_FFFE)) u_carry (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready_w[2]),
        .sysop(sysop), .issue_rd(issue_rd), .retire(retire), .flush(flush),
        .result_valid(result_valid_w[2]), .result_ready(result_ready),
        .result_data(result_data_w[2]), .result_rd(result_rd_w[2]),
        .trap_valid(trap_valid_w[2]), .trap_cause(trap_cause_w[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves reset released just after an edge, so the next rising edge is edge 1.
    task automatic do_reset();
        rst = 1'b1;
        issue_valid = 1'b0;
        sysop = OP_RDCYCLE;
        issue_rd = 5'd0;
        retire = 1'b0;
        flush = 1'b0;
        result_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [4:0] rd);
        issue_valid = 1'b1;
        sysop = op;
        issue_rd = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        issue_valid = 1'b0;
        retire = 1'b0;
        flush = 1'b0;
        result_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (result_valid_w[i] !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid[%0d]: got %b, expected 0", i, result_valid_w[i]); end
            vectors++; if (result_data_w[i] !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_data[%0d]: got %h, expected 0", i, result_data_w[i]); end
            vectors++; if (result_rd_w[i] !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_rd[%0d]: got %0d, expected 0", i, result_rd_w[i]); end
            vectors++; if (trap_valid_w[i] !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_trap_valid[%0d]: got %b, expected 0", i, trap_valid_w[i]); end
            vectors++; if (trap_cause_w[i] !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_trap_cause[%0d]: got %b, expected 0", i, trap_cause_w[i]); end
            vectors++; if (issue_ready_w[i] !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_issue_ready[%0d]: got %b, expected 1", i, issue_ready_w[i]); end
        end
        rst = 1'b0;
    endtask

    task automatic test_cycle_count();
        do_reset();
        repeat (9) tick();
        applyStimulus(OP_RDCYCLE, 5'd17);
        tick();
        issue_valid = 1'b0;
        vectors++; if (result_valid_w[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL cycle_valid: got %b, expected 1", result_valid_w[0]); end
        vectors++; if (result_data_w[0] !== 32'd9) begin miscompares++; $display("[TB] FAIL cycle_data: got %0d, expected 9", result_data_w[0]); end
        vectors++; if (result_rd_w[0] !== 5'd17) begin miscompares++; $display("[TB] FAIL cycle_rd: got %0d, expected 17", result_rd_w[0]); end
        vectors++; if (result_data_w[2] !== 32'h0000_0007) begin miscompares++; $display("[TB] FAIL cycle_data_preload: got %h, expected 00000007", result_data_w[2]); end
        tick();
        vectors++; if (result_valid_w[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL cycle_valid_drop: got %b, expected 0", result_valid_w[0]); end
    endtask

    task automatic test_time();
        do_reset();
        repeat (12) tick();
        applyStimulus(OP_RDTIME, 5'd3);
        tick();
        issue_valid = 1'b0;
        vectors++; if (result_data_w[0] !== 32'd3) begin miscompares++; $display("[TB] FAIL time_div4: got %0d, expected 3", result_data_w[0]); end
        vectors++; if (result_data_w[1] !== 32'd12) begin miscompares++; $display("[TB] FAIL time_div1: got %0d, expected 12", result_data_w[1]); end
    endtask

    task automatic test_instret();
        do_reset();
        retire = 1'b1;
        repeat (5) tick();
        applyStimulus(OP_RDINSTRET, 5'd4);
        tick();
        vectors++; if (result_data_w[0] !== 32'd5) begin miscompares++; $display("[TB] FAIL instret_first: got %0d, expected 5", result_data_w[0]); end
        retire = 1'b0;
        issue_rd = 5'd6;
        tick();
        issue_valid = 1'b0;
        vectors++; if (result_data_w[0] !== 32'd6) begin miscompares++; $display("[TB] FAIL instret_second: got %0d, expected 6", result_data_w[0]); end
        vectors++; if (result_rd_w[0] !== 5'd6) begin miscompares++; $display("[TB] FAIL instret_rd: got %0d, expected 6", result_rd_w[0]); end
    endtask

    // Back-to-back reads across the low-word wrap of the preloaded counter.
    task automatic test_carry();
        do_reset();
        applyStimulus(OP_RDCYCLEH, 5'd1);
        tick();
        vectors++; if (result_data_w[2] !== 32'h0) begin miscompares++; $display("[TB] FAIL carry_hi_before: got %h, expected 00000000", result_data_w[2]); end
        applyStimulus(OP_RDCYCLE, 5'd2);
        tick();
        vectors++; if (result_data_w[2] !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL carry_lo_before: got %h, expected ffffffff", result_data_w[2]); end
        vectors++; if (result_rd_w[2] !== 5'd2) begin miscompares++; $display("[TB] FAIL carry_b2b_rd: got %0d, expected 2", result_rd_w[2]); end
        applyStimulus(OP_RDCYCLEH, 5'd3);
        tick();
        vectors++; if (result_data_w[2] !== 32'h1) begin miscompares++; $display("[TB] FAIL carry_hi_after: got %h, expected 00000001", result_data_w[2]); end
        vectors++; if (result_data_w[0] !== 32'h0) begin miscompares++; $display("[TB] FAIL carry_hi_plain: got %h, expected 00000000", result_data_w[0]); end
        applyStimulus(OP_RDCYCLE, 5'd4);
        tick();
        issue_valid = 1'b0;
        vectors++; if (result_data_w[2] !== 32'h1) begin miscompares++; $display("[TB] FAIL carry_lo_after: got %h, expected 00000001", result_data_w[2]); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        result_ready = 1'b0;
        applyStimulus(OP_RDCYCLE, 5'd3);
        tick();
        vectors++; if (result_valid_w[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_valid: got %b, expected 1", result_valid_w[0]); end
        vectors++; if (issue_ready_w[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_ready_low: got %b, expected 0", issue_ready_w[0]); end
        issue_rd = 5'd7;
        repeat (2) tick();
        vectors++; if (result_data_w[0] !== 32'd0) begin miscompares++; $display("[TB] FAIL bp_data_stable: got %0d, expected 0", result_data_w[0]); end
        vectors++; if (result_rd_w[0] !== 5'd3) begin miscompares++; $display("[TB] FAIL bp_rd_stable: got %0d, expected 3", result_rd_w[0]); end
        vectors++; if (issue_ready_w[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_ready_held: got %b, expected 0", issue_ready_w[0]); end
        result_ready = 1'b1;
        #1;
        vectors++; if (issue_ready_w[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_ready_comb: got %b, expected 1", issue_ready_w[0]); end
        tick();
        issue_valid = 1'b0;
        vectors++; if (result_data_w[0] !== 32'd3) begin miscompares++; $display("[TB] FAIL bp_reload_data: got %0d, expected 3", result_data_w[0]); end
        vectors++; if (result_rd_w[0] !== 5'd7) begin miscompares++; $display("[TB] FAIL bp_reload_rd: got %0d, expected 7", result_rd_w[0]); end
        tick();
        vectors++; if (result_valid_w[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_drain: got %b, expected 0", result_valid_w[0]); end
    endtask

    task automatic test_trap();
        do_reset();
        applyStimulus(OP_SCALL, 5'd0);
        tick();
        issue_valid = 1'b0;
        vectors++; if (trap_valid_w[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL scall_pulse: got %b, expected 1", trap_valid_w[0]); end
        vectors++; if (trap_cause_w[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL scall_cause: got %b, expected 0", trap_cause_w[0]); end
        vectors++; if (result_valid_w[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL scall_no_result: got %b, expected 0", result_valid_w[0]); end
        tick();
        vectors++; if (trap_valid_w[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL scall_pulse_end: got %b, expected 0", trap_valid_w[0]); end
        applyStimulus(OP_SBREAK, 5'd0);
        tick();
        issue_valid = 1'b0;
        vectors++; if (trap_valid_w[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL sbreak_pulse: got %b, expected 1", trap_valid_w[0]); end
        vectors++; if (trap_cause_w[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL sbreak_cause: got %b, expected 1", trap_cause_w[0]); end
        tick();
        vectors++; if (trap_valid_w[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL sbreak_pulse_end: got %b, expected 0", trap_valid_w[0]); end
        vectors++; if (trap_cause_w[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL sbreak_cause_hold: got %b, expected 1", trap_cause_w[0]); end
        applyStimulus(OP_RDCYCLE, 5'd9);
        tick();
        applyStimulus(OP_SCALL, 5'd0);
        tick();
        issue_valid = 1'b0;
        vectors++; if (result_valid_w[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL trap_drains_buffer: got %b, expected 0", result_valid_w[0]); end
        vectors++; if (trap_cause_w[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL trap_cause_rewrite: got %b, expected 0", trap_cause_w[0]); end
    endtask

    task automatic test_flush();
        do_reset();
        result_ready = 1'b0;
        applyStimulus(OP_RDCYCLE, 5'd5);
        tick();
        issue_valid = 1'b0;
        vectors++; if (result_valid_w[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_prefill: got %b, expected 1", result_valid_w[0]); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vectors++; if (result_valid_w[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_empties: got %b, expected 0", result_valid_w[0]); end
        vectors++; if (issue_ready_w[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_ready: got %b, expected 1", issue_ready_w[0]); end
        result_ready = 1'b1;
        applyStimulus(OP_RDCYCLE, 5'd8);
        flush = 1'b1;
        tick();
        vectors++; if (result_valid_w[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_drops_read: got %b, expected 0", result_valid_w[0]); end
        applyStimulus(OP_SBREAK, 5'd0);
        tick();
        flush = 1'b0;
        issue_valid = 1'b0;
        vectors++; if (trap_valid_w[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_drops_trap: got %b, expected 0", trap_valid_w[0]); end
        vectors++; if (trap_cause_w[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_cause_kept: got %b, expected 0", trap_cause_w[0]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        applyStimulus(OP_SCALL, 5'd0);
        tick();
        issue_valid = 1'b0;
        vectors++; if (trap_valid_w[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_pulse_pre: got %b, expected 1", trap_valid_w[0]); end
        rst = 1'b1;
        #1;
        vectors++; if (trap_valid_w[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_pulse_clear: got %b, expected 0", trap_valid_w[0]); end
        do_reset();
        result_ready = 1'b0;
        applyStimulus(OP_RDCYCLE, 5'd12);
        tick();
        tick();
        issue_valid = 1'b0;
        vectors++; if (result_valid_w[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_full_pre: got %b, expected 1", result_valid_w[0]); end
        rst = 1'b1;
        #1;
        vectors++; if (result_valid_w[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_valid_clear: got %b, expected 0", result_valid_w[0]); end
        vectors++; if (result_rd_w[0] !== 5'd0) begin miscompares++; $display("[TB] FAIL midrst_rd_clear: got %0d, expected 0", result_rd_w[0]); end
        rst = 1'b0;
    endtask

    initial begin
        $display("[TB] starting system_unit directed tests");
        test_reset();
        test_cycle_count();
        test_time();
        test_instret();
        test_carry();
        test_back_pressure();
        test_trap();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
